// File: rtl/div_req_ctrl.sv
// Request controller between the issue stage and a multi-cycle divider: issue, wait, writeback.
// Optional macro DIV_REQ_CTRL_RESULT_BYPASS_EN forwards results to writeback in the arrival cycle.
module div_req_ctrl #(
    parameter int WIDTH         = 64,
    parameter int CNT_BITS      = 16,
    parameter int TRANS_ID_BITS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     fu_valid_i,
    output logic                     fu_ready_o,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [WIDTH-1:0]         operand_a_i,
    input  logic [WIDTH-1:0]         operand_b_i,
    input  logic [1:0]               opcode_i,
    output logic                     div_in_vld_o,
    output logic [TRANS_ID_BITS-1:0] div_id_o,
    output logic [WIDTH-1:0]         div_op_a_o,
    output logic [WIDTH-1:0]         div_op_b_o,
    output logic [1:0]               div_opcode_o,
    output logic                     div_flush_o,
    output logic                     div_out_rdy_o,
    input  logic                     div_in_rdy_i,
    input  logic                     div_out_vld_i,
    input  logic [TRANS_ID_BITS-1:0] div_id_i,
    input  logic [WIDTH-1:0]         div_res_i,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [WIDTH-1:0]         wb_result_o,
    output logic [CNT_BITS-1:0]      wb_cycles_o,
    input  logic                     wb_ready_i,
    output logic                     id_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                   state_q;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic [WIDTH-1:0]         op_a_q;
    logic [WIDTH-1:0]         op_b_q;
    logic [1:0]               opcode_q;
    logic [CNT_BITS-1:0]      cnt_q;
    logic [TRANS_ID_BITS-1:0] res_id_q;
    logic [WIDTH-1:0]         res_q;
    logic [CNT_BITS-1:0]      cycles_q;
    logic                     err_q;

    logic                     accept;
    logic                     in_wait;
    logic                     capture;
    logic                     bypass_done;
    logic [CNT_BITS-1:0]      cnt_inc;

    // The reported latency counts the result-arrival cycle, hence the incremented value.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);

    assign fu_ready_o    = (state_q == IDLE) & div_in_rdy_i & ~flush_i;
    assign accept        = fu_valid_i & fu_ready_o;
    assign in_wait       = (state_q == WAIT) & ~flush_i;
    assign div_in_vld_o  = (state_q == ISSUE) & ~flush_i;
    assign div_flush_o   = flush_i;
    assign div_id_o      = id_q;
    assign div_op_a_o    = op_a_q;
    assign div_op_b_o    = op_b_q;
    assign div_opcode_o  = opcode_q;
    assign id_err_o      = err_q;

`ifdef DIV_REQ_CTRL_RESULT_BYPASS_EN
    assign div_out_rdy_o = in_wait & wb_ready_i;
    assign bypass_done   = in_wait & div_out_vld_i & wb_ready_i;
    assign capture       = in_wait & div_out_vld_i & ~wb_ready_i;
    assign wb_valid_o    = ((state_q == RESP) & ~flush_i) | (in_wait & div_out_vld_i);
    assign wb_trans_id_o = in_wait ? div_id_i  : res_id_q;
    assign wb_result_o   = in_wait ? div_res_i : res_q;
    assign wb_cycles_o   = in_wait ? cnt_inc   : cycles_q;
`else
    assign div_out_rdy_o = in_wait;
    assign bypass_done   = 1'b0;
    assign capture       = in_wait & div_out_vld_i;
    assign wb_valid_o    = (state_q == RESP) & ~flush_i;
    assign wb_trans_id_o = res_id_q;
    assign wb_result_o   = res_q;
    assign wb_cycles_o   = cycles_q;
`endif

    // NOTE: all state lives in one clocked block with non-blocking assignments so every
    // register samples pre-edge values; outputs above are pure continuous assigns, so no latches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            cnt_q    <= '0;
            res_id_q <= '0;
            res_q    <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q     <= trans_id_i;
                        op_a_q   <= operand_a_i;
                        op_b_q   <= operand_b_i;
                        opcode_q <= opcode_i;
                        cnt_q    <= '0;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= cnt_inc;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_inc;
                    if ((capture | bypass_done) && (div_id_i != id_q)) begin
                        err_q <= 1'b1;
                    end
                    if (capture) begin
                        res_id_q <= div_id_i;
                        res_q    <= div_res_i;
                        cycles_q <= cnt_inc;
                        state_q  <= RESP;
                    end else if (bypass_done) begin
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    if (wb_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Self-checking bench for div_req_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_div_req_ctrl;

    localparam int W    = 64;
    localparam int CB   = 4;
    localparam int IB   = 4;
    localparam int CMAX = (1 << CB) - 1;
`ifdef DIV_REQ_CTRL_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, fu_valid, fu_ready;
    logic [IB-1:0] trans_id;
    logic [W-1:0]  op_a, op_b;
    logic [1:0]    opcode;
    logic          div_in_vld, div_flush, div_out_rdy;
    logic [IB-1:0] div_id_o;
    logic [W-1:0]  div_op_a, div_op_b;
    logic [1:0]    div_opcode;
    logic          div_in_rdy, div_out_vld;
    logic [IB-1:0] div_id;
    logic [W-1:0]  div_res;
    logic          wb_valid, wb_ready, id_err;
    logic [IB-1:0] wb_trans_id;
    logic [W-1:0]  wb_result;
    logic [CB-1:0] wb_cycles;

    always #5 clk = ~clk;

    div_req_ctrl #(.WIDTH(W), .CNT_BITS(CB), .TRANS_ID_BITS(IB)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .fu_valid_i(fu_valid), .fu_ready_o(fu_ready),
        .trans_id_i(trans_id), .operand_a_i(op_a), .operand_b_i(op_b), .opcode_i(opcode),
        .div_in_vld_o(div_in_vld), .div_id_o(div_id_o), .div_op_a_o(div_op_a),
        .div_op_b_o(div_op_b), .div_opcode_o(div_opcode), .div_flush_o(div_flush),
        .div_out_rdy_o(div_out_rdy), .div_in_rdy_i(div_in_rdy), .div_out_vld_i(div_out_vld),
        .div_id_i(div_id), .div_res_i(div_res),
        .wb_valid_o(wb_valid), .wb_trans_id_o(wb_trans_id), .wb_result_o(wb_result),
        .wb_cycles_o(wb_cycles), .wb_ready_i(wb_ready), .id_err_o(id_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: one outstanding request, its age in cycles, and an optional held result.
    logic          m_busy = 1'b0, m_held = 1'b0, m_err = 1'b0;
    int            m_age = 0;
    logic [IB-1:0] m_id = '0, m_res_id = '0;
    logic [W-1:0]  m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]    m_op = '0;
    logic [CB-1:0] m_cyc = '0;

    function automatic int lat(input int age);
        return (age + 1 > CMAX) ? CMAX : age + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_held <= 1'b0; m_err <= 1'b0; m_age <= 0;
            m_id <= '0; m_a <= '0; m_b <= '0; m_op <= '0;
            m_res_id <= '0; m_res <= '0; m_cyc <= '0;
        end else if (flush) begin
            m_busy <= 1'b0;
            m_held <= 1'b0;
        end else if (!m_busy) begin
            if (fu_valid && div_in_rdy) begin
                m_busy <= 1'b1; m_age <= 0;
                m_id <= trans_id; m_a <= op_a; m_b <= op_b; m_op <= opcode;
            end
        end else if (m_held) begin
            if (wb_ready) begin
                m_busy <= 1'b0;
                m_held <= 1'b0;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age > 0 && div_out_vld) begin
                if (div_id != m_id) m_err <= 1'b1;
                if (BYP && wb_ready) begin
                    m_busy <= 1'b0;
                end else begin
                    m_held   <= 1'b1;
                    m_res    <= div_res;
                    m_res_id <= div_id;
                    m_cyc    <= CB'(lat(m_age));
                end
            end
        end
    end

    logic          e_wait, e_fwd, e_wb_vld;
    logic [IB-1:0] e_wb_id;
    logic [W-1:0]  e_wb_res;
    logic [CB-1:0] e_wb_cyc;

    always @(negedge clk) begin
        e_wait   = m_busy && !m_held && (m_age > 0) && !flush;
        e_fwd    = BYP && e_wait && div_out_vld;
        e_wb_vld = (m_held && !flush) || e_fwd;
        e_wb_id  = e_fwd ? div_id  : m_res_id;
        e_wb_res = e_fwd ? div_res : m_res;
        e_wb_cyc = e_fwd ? CB'(lat(m_age)) : m_cyc;
        check("fu_ready_o",    fu_ready,    !m_busy && div_in_rdy && !flush);
        check("div_in_vld_o",  div_in_vld,  m_busy && (m_age == 0) && !flush);
        check("div_out_rdy_o", div_out_rdy, e_wait && (!BYP || wb_ready));
        check("div_flush_o",   div_flush,   flush);
        check("wb_valid_o",    wb_valid,    e_wb_vld);
        check("id_err_o",      id_err,      m_err);
        check("div_id_o",      div_id_o,    m_id);
        check("div_op_a_o",    div_op_a,    m_a);
        check("div_op_b_o",    div_op_b,    m_b);
        check("div_opcode_o",  div_opcode,  m_op);
        if (e_wb_vld || !rst_n) begin
            check("wb_trans_id_o", wb_trans_id, e_wb_id);
            check("wb_result_o",   wb_result,   e_wb_res);
            check("wb_cycles_o",   wb_cycles,   e_wb_cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IB-1:0] id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op);
        trans_id = id; op_a = a; op_b = b; opcode = op; fu_valid = 1'b1;
        tick();
        fu_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; fu_valid = 1'b0; trans_id = '0; op_a = '0; op_b = '0;
        opcode = '0; div_in_rdy = 1'b1; div_out_vld = 1'b0; div_id = '0; div_res = '0;
        wb_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("reset fu_ready", fu_ready, 1'b1);
        check("reset wb_valid", wb_valid, 1'b0);
        check("reset div_id",   div_id_o, '0);
        tick();
        rst_n = 1'b1;
        tick();

        // 100 / 7, result 4 cycles after issue
        trans_id = 3; op_a = 100; op_b = 7; opcode = 2'd0; fu_valid = 1'b1;
        @(negedge clk); check("accept fu_ready", fu_ready, 1'b1);
        tick(); fu_valid = 1'b0;
        @(negedge clk);
        check("issue in_vld", div_in_vld, 1'b1);
        check("issue op_a", div_op_a, 100);
        check("issue op_b", div_op_b, 7);
        tick();
        @(negedge clk);
        check("issue single cycle", div_in_vld, 1'b0);
        check("wait out_rdy", div_out_rdy, 1'b1);
        tick(); tick(); tick();
        wb_ready = 1'b0; div_out_vld = 1'b1; div_id = 3; div_res = 14;
        tick(); div_out_vld = 1'b0; div_id = '0; div_res = '0;
        @(negedge clk);
        check("wb valid", wb_valid, 1'b1);
        check("wb result 14", wb_result, 14);
        check("wb id 3", wb_trans_id, 3);
        check("wb cycles 5", wb_cycles, 5);
        wb_ready = 1'b1; tick();

        // divider busy for 3 cycles, then long writeback stall
        div_in_rdy = 1'b0; trans_id = 9; op_a = 77; op_b = 10; opcode = 2'd2; fu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy fu_ready", fu_ready, 1'b0);
            check("busy in_vld", div_in_vld, 1'b0);
            tick();
        end
        div_in_rdy = 1'b1;
        @(negedge clk); check("rdy rise accept", fu_ready, 1'b1);
        tick(); fu_valid = 1'b0;
        @(negedge clk); check("late issue in_vld", div_in_vld, 1'b1);
        tick();
        wb_ready = 1'b0; div_out_vld = 1'b1; div_id = 9; div_res = 7;
        tick(); div_out_vld = 1'b0; div_res = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall wb_valid", wb_valid, 1'b1);
            check("stall wb_result", wb_result, 7);
            check("stall wb_id", wb_trans_id, 9);
            check("stall wb_cycles", wb_cycles, 2);
            tick();
        end
        wb_ready = 1'b1;
        @(negedge clk); check("release wb_valid", wb_valid, 1'b1);
        tick();
        @(negedge clk);
        check("idle after wb wb_valid", wb_valid, 1'b0);
        check("idle after wb fu_ready", fu_ready, 1'b1);

        // flush while waiting; the late result must be ignored
        send(1, 50, 5, 2'd0); tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush div_flush", div_flush, 1'b1);
        check("flush out_rdy", div_out_rdy, 1'b0);
        check("flush wb_valid", wb_valid, 1'b0);
        tick(); flush = 1'b0; div_out_vld = 1'b1; div_id = 1; div_res = 10;
        @(negedge clk);
        check("post flush out_rdy", div_out_rdy, 1'b0);
        check("post flush wb_valid", wb_valid, 1'b0);
        check("post flush div_flush", div_flush, 1'b0);
        tick(); div_out_vld = 1'b0;
        @(negedge clk); check("post flush no wb", wb_valid, 1'b0);

        // flush coincident with a request accepts nothing
        fu_valid = 1'b1; flush = 1'b1; trans_id = 12;
        @(negedge clk); check("flush+valid fu_ready", fu_ready, 1'b0);
        tick(); fu_valid = 1'b0; flush = 1'b0;
        @(negedge clk); check("flush+valid no issue", div_in_vld, 1'b0);

        // ID mismatch is sticky
        send(5, 40, 4, 2'd1); tick();
        div_out_vld = 1'b1; div_id = 6; div_res = 3;
        tick(); div_out_vld = 1'b0;
        @(negedge clk); check("id_err set", id_err, 1'b1);
        tick();
        send(2, 9, 3, 2'd0); tick();
        div_out_vld = 1'b1; div_id = 2; div_res = 3;
        tick(); div_out_vld = 1'b0; tick();
        @(negedge clk); check("id_err sticky", id_err, 1'b1);

        // writeback timing relative to result arrival
        send(4, 99, 1, 2'd0); tick();
        div_out_vld = 1'b1; div_id = 4; div_res = 99;
        @(negedge clk);
`ifdef DIV_REQ_CTRL_RESULT_BYPASS_EN
        check("bypass same-cycle wb_valid", wb_valid, 1'b1);
        check("bypass same-cycle wb_result", wb_result, 99);
        tick(); div_out_vld = 1'b0;
        @(negedge clk); check("bypass next fu_ready", fu_ready, 1'b1);
`else
        check("registered no same-cycle wb", wb_valid, 1'b0);
        tick(); div_out_vld = 1'b0;
        @(negedge clk);
        check("registered wb_valid", wb_valid, 1'b1);
        check("registered wb_result", wb_result, 99);
        tick();
`endif

        // latency counter saturates
        send(7, 1, 1, 2'd3);
        repeat (20) tick();
        wb_ready = 1'b0; div_out_vld = 1'b1; div_id = 7; div_res = 1;
        tick(); div_out_vld = 1'b0;
        @(negedge clk); check("cycles saturate", wb_cycles, CMAX);
        wb_ready = 1'b1; tick();

        // reset in mid-operation abandons the request
        send(8, 16, 2, 2'd0); tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset fu_ready", fu_ready, 1'b1);
        check("mid reset in_vld", div_in_vld, 1'b0);
        check("mid reset out_rdy", div_out_rdy, 1'b0);
        check("mid reset id_err", id_err, 1'b0);
        check("mid reset div_id", div_id_o, '0);
        tick(); rst_n = 1'b1; div_out_vld = 1'b1; div_id = 8;
        @(negedge clk); check("after reset no wb", wb_valid, 1'b0);
        tick(); div_out_vld = 1'b0;
        @(negedge clk); check("after reset still no wb", wb_valid, 1'b0);
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                flush = 1'b0; rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            fu_valid    = 1'($urandom_range(0, 1));
            div_in_rdy  = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 29) == 0);
            wb_ready    = 1'($urandom_range(0, 1));
            div_out_vld = ($urandom_range(0, 2) == 0);
            div_id      = ($urandom_range(0, 19) == 0) ? IB'($urandom) : m_id;
            div_res     = {$urandom, $urandom};
            trans_id    = IB'($urandom);
            op_a        = {$urandom, $urandom};
            op_b        = {$urandom, $urandom};
            opcode      = 2'($urandom);
            tick();
        end
        flush = 1'b0; fu_valid = 1'b0; div_out_vld = 1'b0;
        tick();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_req_ctrl.md
DIV_REQ_CTRL -- requirements
Module: div_req_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width.
REQ-002 SHALL have parameter CNT_BITS, default 16: width of the latency counter.
REQ-003 SHALL have port clk_i, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1: kill any in-flight request.
REQ-006 SHALL have ports fu_valid_i, input, 1 and fu_ready_o, output, 1: request handshake from the issue stage.
REQ-007 SHALL have ports trans_id_i, input, TRANS_ID_BITS; operand_a_i and operand_b_i, input, WIDTH each; opcode_i, input, 2 (0 udiv, 1 div, 2 urem, 3 rem).
REQ-008 SHALL have divider-side outputs div_in_vld_o (1), div_id_o (TRANS_ID_BITS), div_op_a_o (WIDTH), div_op_b_o (WIDTH), div_opcode_o (2), div_flush_o (1), div_out_rdy_o (1).
REQ-009 SHALL have divider-side inputs div_in_rdy_i (1), div_out_vld_i (1), div_id_i (TRANS_ID_BITS), div_res_i (WIDTH).
REQ-010 SHALL have writeback outputs wb_valid_o (1), wb_trans_id_o (TRANS_ID_BITS), wb_result_o (WIDTH), wb_cycles_o (CNT_BITS), plus wb_ready_i, input, 1.
REQ-011 SHALL have output id_err_o, 1: sticky flag for a result-ID mismatch.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 fu_ready_o SHALL equal (state==IDLE) & div_in_rdy_i & ~flush_i.
REQ-014 On fu_valid_i & fu_ready_o: SHALL register the id, operands and opcode, clear the latency counter, and go to ISSUE.
REQ-015 In ISSUE: SHALL assert div_in_vld_o for exactly one cycle with the registered fields on div_* outputs, then go to WAIT. div_in_vld_o SHALL therefore follow the accepting div_in_rdy_i cycle by exactly one cycle.
REQ-016 div_in_vld_o SHALL be 0 in every state other than ISSUE.
REQ-017 div_id_o, div_op_a_o, div_op_b_o and div_opcode_o SHALL hold the registered values at all times.
REQ-018 In WAIT: div_out_rdy_o SHALL be 1. On div_out_vld_i, SHALL capture div_res_i, div_id_i and the counter, and go to RESP.
REQ-019 If the captured div_id_i differs from the registered id, SHALL set id_err_o; it remains set until reset.
REQ-020 The latency counter SHALL increment each cycle in ISSUE and WAIT and saturate at all-ones.
REQ-021 In RESP: wb_valid_o SHALL be 1 and wb_* SHALL be stable until wb_ready_i. On wb_ready_i, SHALL go to IDLE; a new accept is possible in the following cycle.
REQ-022 div_out_rdy_o SHALL be 0 outside WAIT, so at most one result is ever held.
REQ-023 flush_i in any state SHALL:
  - drive div_flush_o=1 in the same cycle;
  - force div_in_vld_o=0, wb_valid_o=0 and div_out_rdy_o=0 in that cycle;
  - send the FSM to IDLE and discard any captured result.
REQ-024 flush_i in the same cycle as fu_valid_i SHALL accept nothing.
REQ-025 Outside flush, div_flush_o SHALL be 0.

Reset
REQ-026 Reset SHALL put the FSM in IDLE and clear all registers.
REQ-027 While in reset: fu_ready_o=div_in_rdy_i, and all other outputs 0.
REQ-028 Reset asserted mid-operation SHALL abandon the request with no writeback.

Configuration
REQ-029 With macro DIV_REQ_CTRL_RESULT_BYPASS_EN defined, WAIT SHALL forward the result to writeback combinationally:
  - wb_valid_o=div_out_vld_i;
  - wb_trans_id_o=div_id_i, wb_result_o=div_res_i, wb_cycles_o=counter;
  - div_out_rdy_o=wb_ready_i;
  - on div_out_vld_i & wb_ready_i, go straight to IDLE, skipping RESP;
  - on div_out_vld_i & ~wb_ready_i, capture the result and go to RESP.
REQ-030 Without DIV_REQ_CTRL_RESULT_BYPASS_EN, results SHALL be registered only (REQ-018).

Verification
REQ-031 Accept 100/7, opcode 0, id 3; divider answers 4 cycles after div_in_vld_o -> div_in_vld_o high exactly 1 cycle after accept; wb_result_o=14, wb_trans_id_o=3, wb_cycles_o=5.
REQ-032 div_in_rdy_i=0 with fu_valid_i=1 for 3 cycles -> fu_ready_o=0 and no div_in_vld_o; accept in the cycle div_in_rdy_i rises.
REQ-033 Result ready, wb_ready_i low for 6 cycles -> wb_valid_o and wb_* stable for 6 cycles; IDLE one cycle after wb_ready_i.
REQ-034 flush_i in WAIT, then div_out_vld_i on the next cycle -> div_flush_o=1 in the flush cycle; no wb_valid_o.
REQ-035 Issue id 5, divider returns id 6 -> id_err_o=1 and stays 1 through later good transactions.
REQ-036 Bypass build, wb_ready_i=1, result arrives -> wb_valid_o in the same cycle as div_out_vld_i; fu_ready_o=1 the next cycle.
